// File: rtl/genie_wrr_sched.sv
// genie_wrr_sched: weighted round-robin, packet-aware grant controller.
// Each input may send up to weight[i] whole packets per turn before the
// grant rotates. The select is combinational (flow-through); only the
// holder, its packet budget, the packet lock and the weights are registered.
module genie_wrr_sched #(
  parameter int NI             = 4,
  parameter int WBITS          = 4,
  parameter int DEFAULT_WEIGHT = 1,
  parameter int NIBITS         = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NI-1:0]     i_valid,
  input  logic [NI-1:0]     i_eop,
  output logic [NI-1:0]     o_ready,
  input  logic              i_ready,
  output logic [NIBITS-1:0] o_sel,
  output logic              o_grant_valid,
  output logic              o_eop,
  input  logic              cfg_we,
  input  logic [NIBITS-1:0] cfg_idx,
  input  logic [WBITS-1:0]  cfg_wdata,
  output logic [WBITS-1:0]  o_budget
);

  typedef enum logic {S_ARB = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t             state_reg;
  logic [NIBITS-1:0]  holder_reg;
  logic [WBITS-1:0]   budget_reg;
  logic [WBITS-1:0]   weight_reg [NI];

  logic [NI-1:0]      eligible;
  logic [NIBITS-1:0]  cand;
  logic [NIBITS-1:0]  rot_sel;
  logic               any_eligible;
  logic               holder_stay;
  logic [NIBITS-1:0]  sel;
  logic               grant_valid;
  logic               sel_eop;
  logic               data_sent;
  logic [WBITS-1:0]   load_budget;

  // Decrement by one packet when an eop beat goes out, never below zero.
  function automatic logic [WBITS-1:0] sat_dec(input logic [WBITS-1:0] v, input logic dec);
    return (dec && (v != '0)) ? (v - WBITS'(1)) : v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_per_input
      // A zero weight removes the input from arbitration entirely.
      assign eligible[gi] = i_valid[gi] && (weight_reg[gi] != '0);
      // Ready only to the selected input; mid-packet the holder sees ready
      // even while its valid is low so it can resume without re-arbitration.
      assign o_ready[gi]  = i_ready && (sel == NIBITS'(gi)) &&
                            (grant_valid || (state_reg == S_LOCKED));
    end
  endgenerate

  // Rotating search: first eligible input after the holder, wrapping to the holder itself.
  always_comb begin
    any_eligible = 1'b0;
    rot_sel      = holder_reg;
    cand         = '0;
    for (int k = 1; k <= NI; k++) begin
      cand = NIBITS'((int'(holder_reg) + k) % NI);
      if (!any_eligible && eligible[cand]) begin
        any_eligible = 1'b1;
        rot_sel      = cand;
      end
    end
  end

  // Select: locked holder, or holder with remaining budget, or the rotate winner.
  always_comb begin
    holder_stay = eligible[holder_reg] && (budget_reg != '0);
    if (state_reg == S_LOCKED) begin
      sel         = holder_reg;
      grant_valid = i_valid[holder_reg];
    end else if (holder_stay) begin
      sel         = holder_reg;
      grant_valid = 1'b1;
    end else begin
      sel         = rot_sel;
      grant_valid = any_eligible;
    end
    sel_eop     = i_eop[sel];
    data_sent   = grant_valid && i_ready;
    // A fresh turn reloads from the winner's weight; staying keeps the budget.
    load_budget = holder_stay ? budget_reg : weight_reg[sel];
  end

  // Packet-lock FSM with holder and budget tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_ARB;
      holder_reg <= NIBITS'(NI - 1);
      budget_reg <= '0;
    end else begin
      case (state_reg)
        S_ARB: begin
          if (data_sent) begin
            holder_reg <= sel;
            budget_reg <= sat_dec(load_budget, sel_eop);
            if (!sel_eop) state_reg <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (data_sent && sel_eop) begin
            budget_reg <= sat_dec(budget_reg, 1'b1);
            state_reg  <= S_ARB;
          end
        end
        default: state_reg <= S_ARB;
      endcase
    end
  end

  // Runtime weight registers; out-of-range indices match no entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) weight_reg[i] <= WBITS'(DEFAULT_WEIGHT);
    end else if (cfg_we) begin
      for (int i = 0; i < NI; i++) begin
        if (cfg_idx == NIBITS'(i)) weight_reg[i] <= cfg_wdata;
      end
    end
  end

  assign o_sel         = sel;
  assign o_grant_valid = grant_valid;
  assign o_eop         = sel_eop;
  assign o_budget      = budget_reg;

endmodule

// File: tb/tb_genie_wrr_sched.sv
// Testbench for genie_wrr_sched: directed test-plan steps followed by a
// randomized phase, all checked against a packet-level reference model.
module tb_genie_wrr_sched;

  localparam int NI     = 4;
  localparam int WBITS  = 4;
  localparam int NIBITS = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NI-1:0]     i_valid = '0;
  logic [NI-1:0]     i_eop = '0;
  logic              i_ready = 1'b0;
  logic              cfg_we = 1'b0;
  logic [NIBITS-1:0] cfg_idx = '0;
  logic [WBITS-1:0]  cfg_wdata = '0;
  logic [NI-1:0]     o_ready;
  logic [NIBITS-1:0] o_sel;
  logic              o_grant_valid;
  logic              o_eop;
  logic [WBITS-1:0]  o_budget;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: whose turn it is, packets left in the turn, mid-packet flag.
  int m_w [NI];
  bit m_locked;
  int m_holder;
  int m_budget;

  genie_wrr_sched #(.NI(NI), .WBITS(WBITS), .DEFAULT_WEIGHT(1)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_eop(i_eop),
    .o_ready(o_ready), .i_ready(i_ready), .o_sel(o_sel),
    .o_grant_valid(o_grant_valid), .o_eop(o_eop), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .o_budget(o_budget)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig(input int i);
    return i_valid[i] && (m_w[i] != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) m_w[i] = 1;
    m_locked = 0;
    m_holder = NI - 1;
    m_budget = 0;
  endtask

  // Whose beat is presented this cycle, and is it valid.
  task automatic model_pick(output int sel, output bit gv);
    sel = m_holder;
    gv  = 0;
    if (m_locked) begin
      gv = i_valid[m_holder];
    end else if (elig(m_holder) && m_budget > 0) begin
      gv = 1;
    end else begin
      for (int k = 1; k <= NI; k++) begin
        int c;
        c = (m_holder + k) % NI;
        if (!gv && elig(c)) begin
          sel = c;
          gv  = 1;
        end
      end
    end
  endtask

  // Advance the model by one clock given the presented beat.
  task automatic model_advance(input int sel, input bit gv);
    bit sent, eop, new_turn;
    int b;
    sent = gv && i_ready;
    eop  = i_eop[sel];
    if (sent && !m_locked) begin
      new_turn = !(elig(m_holder) && m_budget > 0);
      b = (new_turn ? m_w[sel] : m_budget) - (eop ? 1 : 0);
      m_budget = (b < 0) ? 0 : b;
      m_holder = sel;
      m_locked = !eop;
    end else if (sent && eop) begin
      m_budget = (m_budget > 0) ? m_budget - 1 : 0;
      m_locked = 0;
    end
    if (cfg_we && int'(cfg_idx) < NI) m_w[cfg_idx] = int'(cfg_wdata);
  endtask

  // One clock: check all outputs mid-cycle, log the transaction, advance.
  task automatic step(input int exp_sel);
    int sel;
    bit gv;
    logic [NI-1:0] rdy;
    @(negedge clk);
    model_pick(sel, gv);
    rdy = '0;
    if (i_ready && (gv || m_locked)) rdy[sel] = 1'b1;
    chk("sel", 32'(o_sel), 32'(sel));
    chk("grant_valid", 32'(o_grant_valid), 32'(gv));
    chk("ready", 32'(o_ready), 32'(rdy));
    chk("eop", 32'(o_eop), 32'(i_eop[sel]));
    chk("budget", 32'(o_budget), 32'(m_budget));
    if (exp_sel >= 0) chk("plan_sel", 32'(o_sel), 32'(exp_sel));
    if (gv && i_ready)
      $display("[TB] t=%0t send in=%0d eop=%0b budget_before=%0d", $time, sel, i_eop[sel], m_budget);
    model_advance(sel, gv);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse away from the clock edge, with reset-state checks.
  task automatic do_reset();
    i_valid = '0;
    i_eop   = '0;
    cfg_we  = 1'b0;
    reset   = 1'b1;
    model_reset();
    #1;
    chk("rst_sel", 32'(o_sel), 32'(NI - 1));
    chk("rst_gv", 32'(o_grant_valid), 32'(0));
    chk("rst_ready", 32'(o_ready), 32'(0));
    chk("rst_budget", 32'(o_budget), 32'(0));
    #1;
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int val);
    i_valid   = '0;
    cfg_we    = 1'b1;
    cfg_idx   = NIBITS'(idx);
    cfg_wdata = WBITS'(val);
    step(-1);
    cfg_we    = 1'b0;
  endtask

  initial begin
    int seq2 [6];
    int seq3 [9];
    int bud3 [9];
    int seq5 [4];
    seq2 = '{0, 1, 2, 3, 0, 1};
    seq3 = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    bud3 = '{2, 1, 0, 0, 0, 0, 2, 1, 0};
    seq5 = '{0, 1, 3, 0};
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Equal weights, single-beat packets: plain round robin.
    i_valid = '1; i_eop = '1; i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(seq2[k]);
      chk("rr_budget_after", 32'(o_budget), 32'(0));
    end

    // Weights {3,1,1,1}: input 0 gets three packets per turn.
    do_reset();
    cfg_write(0, 3);
    i_valid = '1; i_eop = '1; i_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(seq3[k]);
      chk("wrr_budget_after", 32'(o_budget), 32'(bud3[k]));
    end

    // Four-beat packet on input 1 holds the grant while input 2 waits.
    i_valid = 4'b0010; i_eop = 4'b0000;
    step(1);
    i_valid = 4'b0110;
    step(1);
    step(1);
    i_eop = 4'b0010;
    step(1);
    i_valid = 4'b0100; i_eop = 4'b0100;
    step(2);

    // Zero weight removes input 2 from arbitration.
    do_reset();
    cfg_write(2, 0);
    i_valid = '1; i_eop = '1; i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(seq5[k]);
      chk("zero_w_ready2", 32'(o_ready[2]), 32'(0));
    end

    // Input 0 locked mid-packet through backpressure and a valid gap.
    i_valid = 4'b0001; i_eop = 4'b0000; i_ready = 1'b1;
    step(0);
    i_valid = 4'b1111; i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0);
      chk("lock_budget_hold", 32'(o_budget), 32'(1));
    end
    i_valid = 4'b1110; i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(0);
      chk("lock_gap_ready0", 32'(o_ready[0]), 32'(1));
    end
    i_valid = 4'b1111; i_eop = 4'b0001;
    step(0);
    chk("lock_eop_budget", 32'(o_budget), 32'(0));

    // Reset while input 2 is locked mid-packet drops the lock.
    cfg_write(2, 2);
    i_valid = 4'b0100; i_eop = 4'b0000; i_ready = 1'b1;
    step(2);
    step(2);
    do_reset();
    i_valid = 4'b0101; i_eop = 4'b0101;
    step(0);
    chk("post_reset_budget", 32'(o_budget), 32'(0));

    // Randomized traffic, backpressure and weight reprogramming.
    for (int k = 0; k < 400; k++) begin
      i_valid   = NI'($urandom);
      i_eop     = NI'($urandom);
      i_ready   = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 8) == 0;
      cfg_idx   = NIBITS'($urandom);
      cfg_wdata = WBITS'($urandom % 4);
      step(-1);
    end
    cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
